// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mid_t;

    // Highest address bit an access may set without being out of range.
    localparam int LEGAL_ADDR_MSB = 11;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-way round-robin picker: one-hot grant from a 2-bit request vector.
// Latency: purely combinational.
// Backpressure: none; the caller decides what a grant means.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  mid_t       i_ptr,
    output logic [1:0] o_gnt
);

    // A lone requester always wins; on contention the pointer breaks the tie.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_ptr == M0) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter with bounded bus lock for a single-port data memory.
// Latency: grant and memory access in the request cycle; read data registered, valid one cycle later.
// Backpressure: a requester waits with req held until granted; responses cannot be stalled.
// Optional range checking of addresses is enabled by defining DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_RANGE_CHK_EN
    output logic              m0_err,
    output logic              m1_err,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    state_t            r_state,    w_state_nxt;
    mid_t              r_rr_ptr,   w_rr_ptr_nxt;
    mid_t              r_owner,    w_owner_nxt;
    logic [CW-1:0]     r_lock_cnt, w_lock_cnt_nxt;
    logic [1:0]        r_blk,      w_blk_nxt;
    logic [CW-1:0]     w_cnt_inc;
    logic [1:0]        w_req, w_lock, w_req_eff, w_pick, w_gnt;
    mid_t              w_win;
    logic              w_we, w_bad;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              r_m0_rvalid, r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_rdata,  r_m1_rdata;
    logic              r_m0_err,    r_m1_err;

    assign w_req  = {m1_req,  m0_req};
    assign w_lock = {m1_lock, m0_lock};
    // A master whose lock was cut off at the limit stays out until it drops lock.
    assign w_req_eff = w_req & ~(r_blk & w_lock);
    assign w_win     = w_pick[1] ? M1 : M0;
    assign w_cnt_inc = r_lock_cnt + 1'b1;

    rr_arb2 u_rr_arb2 (
        .i_req (w_req_eff),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick)
    );

    // Lock FSM state, round-robin pointer, owner, lock counter and lock blocking flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_rr_ptr   <= M0;
            r_owner    <= M0;
            r_lock_cnt <= '0;
            r_blk      <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_blk      <= w_blk_nxt;
        end
    end

    // Next-state and grant decode; reset forces the grant low.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_blk_nxt      = r_blk & w_lock;
        w_gnt          = 2'b00;
        case (r_state)
            ARB: begin
                w_gnt = w_pick;
                if (|w_pick) begin
                    w_rr_ptr_nxt = (w_win == M0) ? M1 : M0;
                    if (w_lock[w_win]) begin
                        if (MAX_LOCK == 1) begin
                            w_blk_nxt[w_win] = 1'b1;
                        end else begin
                            w_state_nxt    = LOCKED;
                            w_owner_nxt    = w_win;
                            w_lock_cnt_nxt = CW'(1);
                        end
                    end
                end
            end
            LOCKED: begin
                w_gnt[r_owner] = w_req[r_owner];
                if (!w_lock[r_owner]) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                end else if (w_cnt_inc == CW'(MAX_LOCK)) begin
                    w_state_nxt        = ARB;
                    w_lock_cnt_nxt     = '0;
                    w_rr_ptr_nxt       = (r_owner == M0) ? M1 : M0;
                    w_blk_nxt[r_owner] = 1'b1;
                end else begin
                    w_lock_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = ARB;
        endcase
        if (rst) begin
            w_gnt = 2'b00;
        end
    end

    assign m0_gnt  = w_gnt[0];
    assign m1_gnt  = w_gnt[1];
    assign w_we    = w_gnt[1] ? m1_we    : m0_we;
    assign w_addr  = w_gnt[1] ? m1_addr  : m0_addr;
    assign w_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign w_bad = (w_addr[ADDR_W-1:LEGAL_ADDR_MSB+1] != '0) || (w_addr[1:0] != 2'b00);
`else
    assign w_bad = 1'b0;
`endif

    assign mem_we    = (|w_gnt) & w_we & ~w_bad;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;

    // Capture read data (or zero for a rejected read) for the granted master.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt[0] & ~w_we;
            r_m1_rvalid <= w_gnt[1] & ~w_we;
            r_m0_err    <= w_gnt[0] & w_bad;
            r_m1_err    <= w_gnt[1] & w_bad;
            if (w_gnt[0] && !w_we) begin
                r_m0_rdata <= w_bad ? '0 : mem_rdata;
            end
            if (w_gnt[1] && !w_we) begin
                r_m1_rdata <= w_bad ? '0 : mem_rdata;
            end
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign m0_err = r_m0_err;
    assign m1_err = r_m1_err;
`else
    // Error flags only reach ports when range checking is built in.
    logic w_err_unused;
    assign w_err_unused = r_m0_err ^ r_m1_err;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural single-port memory.
// Latency: expected responses are queued at grant and checked one cycle later.
// Backpressure: none; stimulus is a fixed per-cycle table.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_RANGE_CHK_EN
    logic        m0_err, m1_err;
`endif

    logic [31:0] mem_arr [0:1023];
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        bit          mid;
        bit          rv;
        bit          err;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t q[$];
    int   cyc;
    int   errs;
    int   checks;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
`ifdef DMEM_ARB_RANGE_CHK_EN
        .m0_err    (m0_err),
        .m1_err    (m1_err),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the clock edge.
    assign mem_rdata = mem_arr[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check due responses and this cycle's grant, queue the expected response.
    task automatic tick(input logic [1:0] eg);
        rsp_t        e;
        bit          have;
        bit          we, bad;
        logic [31:0] addr, wd;
        e = '{mid: 1'b0, rv: 1'b0, err: 1'b0, data: 32'h0, due: 0};
        @(negedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            check("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
            check("rst_mem_we", mem_we, 1'b0);
        end else begin
            have = (q.size() > 0) && (q[0].due == cyc);
            if (have) e = q.pop_front();
            check("m0_rvalid", m0_rvalid, have && !e.mid && e.rv);
            if (have && !e.mid && e.rv) check("m0_rdata", m0_rdata, e.data);
            check("m1_rvalid", m1_rvalid, have && e.mid && e.rv);
            if (have && e.mid && e.rv) check("m1_rdata", m1_rdata, e.data);
`ifdef DMEM_ARB_RANGE_CHK_EN
            check("m0_err", m0_err, have && !e.mid && e.err);
            check("m1_err", m1_err, have && e.mid && e.err);
`endif
            check("gnt", {m1_gnt, m0_gnt}, eg);
            we   = eg[1] ? m1_we    : m0_we;
            addr = eg[1] ? m1_addr  : m0_addr;
            wd   = eg[1] ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_RANGE_CHK_EN
            bad = (addr[31:12] != 20'h0) || (addr[1:0] != 2'b00);
`else
            bad = 1'b0;
`endif
            check("mem_we", mem_we, (|eg) & we & ~bad);
            if ((|eg) && !bad) begin
                check("mem_addr", mem_addr, addr);
                if (we) check("mem_wdata", mem_wdata, wd);
            end
            if ((|eg) && (!we || bad)) begin
                q.push_back('{mid: eg[1], rv: !we, err: bad,
                              data: bad ? 32'h0 : ref_mem[addr[11:2]], due: cyc + 1});
            end
            if ((|eg) && we && !bad) ref_mem[addr[11:2]] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2'b00);
        tick(2'b00);
        rst = 1'b0;
    endtask

    initial begin
        errs = 0; checks = 0; cyc = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        idle();
        m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        @(posedge clk);
        #1;
        do_reset();
        tick(2'b00);
        check("reset_m0_rdata", m0_rdata, 32'h0);
        check("reset_m1_rdata", m1_rdata, 32'h0);

        // Store then load by M0; the load sees the new data.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        tick(2'b01);
        m0_we = 1'b0;
        tick(2'b01);
        idle();
        tick(2'b00);

        // Round-robin under full contention: M0, M1, M0, M1.
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b0;
        m0_addr = 32'h20; m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            m0_wdata = 32'h1111_0000 + 32'(i);
            tick((i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // M0 alone once so the pointer favours M1, then M1 locks against M0.
        m1_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h10;
        tick(2'b01);
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            m1_addr  = 32'h100 + 32'(4 * i);
            m1_wdata = 32'hA000 + 32'(i);
            m0_addr  = 32'h100 + 32'(4 * ((i >= 8) ? i - 8 : 0));
            tick((i < 8) ? 2'b10 : 2'b01);
        end
        // Lock dropped: M1 wins the next contended round, then M0.
        m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 32'h104;
        tick(2'b10);
        m0_addr = 32'h11C;
        tick(2'b01);
        idle();
        tick(2'b00);

        // Reset right after a locking M0 read: no response, back to ARB with pointer at M0.
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 32'h10;
        tick(2'b01);
        rst = 1'b1; m0_lock = 1'b0;
        tick(2'b00);
        rst = 1'b0; m1_req = 1'b1; m1_addr = 32'h20;
        tick(2'b01);
        tick(2'b10);
        idle();
        tick(2'b00);

`ifdef DMEM_ARB_RANGE_CHK_EN
        // Out-of-range and misaligned accesses are accepted but not forwarded.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h55AA55AA;
        tick(2'b01);
        m0_addr = 32'h2; m0_wdata = 32'h00000BAD;
        tick(2'b01);
        m0_we = 1'b0; m0_addr = 32'h1000;
        tick(2'b01);
        m0_addr = 32'h0;
        tick(2'b01);
        idle();
        tick(2'b00);
`endif

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
